// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM states and
// the byte-offset helper used to locate the register index in an address.
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } axi_resp_e;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_e;

   // Number of address bits that select a byte within one data word.
   function automatic int calc_addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// AXI4-Lite subordinate register bank with independent write and read FSMs.
// Optional macro AXIL_REG_BANK_SLVERR_EN: out-of-range accesses answer SLVERR
// instead of OKAY. Out-of-range writes are dropped and out-of-range reads
// return zero in either build, and handshake timing does not change.
module axil_reg_bank
   import axi4_lite_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_REGS   = 4
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [DATA_WIDTH-1:0] s_axi_wdata,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready
);

   localparam int ADDR_LSB = calc_addr_lsb(DATA_WIDTH);
   localparam int IDX_W    = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * (DATA_WIDTH / 8));

`ifdef AXIL_REG_BANK_SLVERR_EN
   localparam axi_resp_e OOR_RESP = RESP_SLVERR;
`else
   localparam axi_resp_e OOR_RESP = RESP_OKAY;
`endif

   logic                  rst_pipe;
   logic                  rst_done;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   w_state_e              w_state;
   logic                  aw_captured;
   logic                  w_captured;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  have_aw;
   logic                  have_w;
   logic                  wr_fire;
   logic                  wr_in_range;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [IDX_W-1:0]      wr_idx;

   r_state_e              r_state;
   logic                  ar_hs;
   logic                  rd_in_range;
   logic [IDX_W-1:0]      rd_idx;

   // Readies stay low until two clean edges have passed after reset release.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rst_pipe <= 1'b0;
         rst_done <= 1'b0;
      end else begin
         rst_pipe <= 1'b1;
         rst_done <= rst_pipe;
      end
   end

   assign s_axi_awready = rst_done && (w_state == W_IDLE) && !aw_captured;
   assign s_axi_wready  = rst_done && (w_state == W_IDLE) && !w_captured;
   assign s_axi_arready = rst_done && (r_state == R_IDLE);

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid && s_axi_wready;

   // A write completes on the cycle the later of AW and W is seen; the
   // earlier one may already sit in the capture registers.
   assign have_aw     = aw_captured || aw_hs;
   assign have_w      = w_captured || w_hs;
   assign wr_addr     = aw_captured ? aw_addr_q : s_axi_awaddr;
   assign wr_data     = w_captured ? w_data_q : s_axi_wdata;
   assign wr_fire     = (w_state == W_IDLE) && have_aw && have_w;
   assign wr_in_range = wr_addr < ADDR_LIMIT;
   assign wr_idx      = wr_addr[ADDR_LSB +: IDX_W];

   assign ar_hs       = s_axi_arvalid && s_axi_arready;
   assign rd_in_range = s_axi_araddr < ADDR_LIMIT;
   assign rd_idx      = s_axi_araddr[ADDR_LSB +: IDX_W];

   // Register storage; out-of-range writes never touch it.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_fire && wr_in_range) begin
         regs[wr_idx] <= wr_data;
      end
   end

   // Write channel FSM: collect AW and W in any order, then hold the
   // response until the manager takes it.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state      <= W_IDLE;
         aw_captured  <= 1'b0;
         w_captured   <= 1'b0;
         aw_addr_q    <= '0;
         w_data_q     <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_hs) begin
                  aw_captured <= 1'b1;
                  aw_addr_q   <= s_axi_awaddr;
               end
               if (w_hs) begin
                  w_captured <= 1'b1;
                  w_data_q   <= s_axi_wdata;
               end
               if (wr_fire) begin
                  s_axi_bvalid <= 1'b1;
                  s_axi_bresp  <= wr_in_range ? RESP_OKAY : OOR_RESP;
                  w_state      <= W_RESP;
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid <= 1'b0;
                  aw_captured  <= 1'b0;
                  w_captured   <= 1'b0;
                  w_state      <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read channel FSM: sample the register on the AR handshake so a write
   // finishing the same cycle is not yet visible, then hold until taken.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state      <= R_IDLE;
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  s_axi_rvalid <= 1'b1;
                  s_axi_rdata  <= rd_in_range ? regs[rd_idx] : '0;
                  s_axi_rresp  <= rd_in_range ? RESP_OKAY : OOR_RESP;
                  r_state      <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  s_axi_rvalid <= 1'b0;
                  r_state      <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Self-checking bench for axil_reg_bank: directed vector table, hand-written
// corner sequences and randomized traffic against an array model.
module tb_axil_reg_bank;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int NR = 4;

`ifdef AXIL_REG_BANK_SLVERR_EN
   localparam logic [1:0] OOR_RESP = 2'b10;
`else
   localparam logic [1:0] OOR_RESP = 2'b00;
`endif

   logic          aclk;
   logic          aresetn;
   logic [AW-1:0] s_axi_awaddr;
   logic          s_axi_awvalid;
   logic          s_axi_awready;
   logic [DW-1:0] s_axi_wdata;
   logic          s_axi_wvalid;
   logic          s_axi_wready;
   logic [1:0]    s_axi_bresp;
   logic          s_axi_bvalid;
   logic          s_axi_bready;
   logic [AW-1:0] s_axi_araddr;
   logic          s_axi_arvalid;
   logic          s_axi_arready;
   logic [DW-1:0] s_axi_rdata;
   logic [1:0]    s_axi_rresp;
   logic          s_axi_rvalid;
   logic          s_axi_rready;

   int n_compared = 0;
   int n_mismatched = 0;
   int b_hs_count = 0;

   logic [31:0] model_regs [NR];

   typedef struct {
      bit          is_write;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
   } vec_t;

   vec_t vecs [15];

   axil_reg_bank #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .NUM_REGS  (NR)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .s_axi_awaddr (s_axi_awaddr),
      .s_axi_awvalid(s_axi_awvalid),
      .s_axi_awready(s_axi_awready),
      .s_axi_wdata  (s_axi_wdata),
      .s_axi_wvalid (s_axi_wvalid),
      .s_axi_wready (s_axi_wready),
      .s_axi_bresp  (s_axi_bresp),
      .s_axi_bvalid (s_axi_bvalid),
      .s_axi_bready (s_axi_bready),
      .s_axi_araddr (s_axi_araddr),
      .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready),
      .s_axi_rdata  (s_axi_rdata),
      .s_axi_rresp  (s_axi_rresp),
      .s_axi_rvalid (s_axi_rvalid),
      .s_axi_rready (s_axi_rready)
   );

   // Free-running clock.
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Count every accepted write response.
   always @(posedge aclk) begin
      if (aresetn && s_axi_bvalid && s_axi_bready) b_hs_count++;
   end

   // Global watchdog so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual=still running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
      end
   endtask

   task automatic reportTimeout(input string what);
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: actual=no handshake required=handshake within budget", what);
   endtask

   function automatic logic [31:0] modelRead(input logic [31:0] addr);
      if (addr < NR * 4) return model_regs[addr / 4];
      return 32'h0;
   endfunction

   function automatic logic [1:0] modelResp(input logic [31:0] addr);
      return (addr < NR * 4) ? 2'b00 : OOR_RESP;
   endfunction

   // Full write transaction starting at a negedge; AW and W can be delayed
   // independently. Also checks exactly one response handshake occurred.
   task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_delay, input int w_delay, output logic [1:0] resp);
      int cnt;
      int aw_wait;
      int w_wait;
      int b_before;
      bit aw_done;
      bit w_done;
      bit aw_hs;
      bit w_hs;
      resp = 2'bxx;
      b_before = b_hs_count;
      s_axi_bready = 1'b1;
      s_axi_awaddr = addr;
      s_axi_wdata = data;
      aw_wait = aw_delay;
      w_wait = w_delay;
      aw_done = 1'b0;
      w_done = 1'b0;
      s_axi_awvalid = (aw_wait == 0);
      s_axi_wvalid = (w_wait == 0);
      cnt = 0;
      while (!(aw_done && w_done) && cnt < 100) begin
         aw_hs = s_axi_awvalid && s_axi_awready;
         w_hs = s_axi_wvalid && s_axi_wready;
         @(negedge aclk);
         cnt++;
         if (aw_hs) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
         if (w_hs) begin w_done = 1'b1; s_axi_wvalid = 1'b0; end
         if (aw_wait > 0) aw_wait--;
         if (w_wait > 0) w_wait--;
         if (!aw_done && aw_wait == 0) s_axi_awvalid = 1'b1;
         if (!w_done && w_wait == 0) s_axi_wvalid = 1'b1;
      end
      s_axi_awvalid = 1'b0;
      s_axi_wvalid = 1'b0;
      if (!(aw_done && w_done)) begin
         reportTimeout("write_addr_data");
         return;
      end
      cnt = 0;
      while (!s_axi_bvalid && cnt < 100) begin
         @(negedge aclk);
         cnt++;
      end
      if (!s_axi_bvalid) begin
         reportTimeout("write_resp");
         return;
      end
      resp = s_axi_bresp;
      @(negedge aclk);
      checkOutput("b_count", b_hs_count - b_before, 1);
   endtask

   // Full read transaction starting at a negedge.
   task automatic axiRead(input logic [31:0] addr, output logic [31:0] rdata, output logic [1:0] resp);
      int cnt;
      bit ar_hs;
      rdata = 32'hxxxxxxxx;
      resp = 2'bxx;
      s_axi_rready = 1'b1;
      s_axi_araddr = addr;
      s_axi_arvalid = 1'b1;
      ar_hs = 1'b0;
      cnt = 0;
      while (!ar_hs && cnt < 100) begin
         ar_hs = s_axi_arvalid && s_axi_arready;
         @(negedge aclk);
         cnt++;
      end
      s_axi_arvalid = 1'b0;
      if (!ar_hs) begin
         reportTimeout("read_addr");
         return;
      end
      cnt = 0;
      while (!s_axi_rvalid && cnt < 100) begin
         @(negedge aclk);
         cnt++;
      end
      if (!s_axi_rvalid) begin
         reportTimeout("read_data");
         return;
      end
      rdata = s_axi_rdata;
      resp = s_axi_rresp;
      @(negedge aclk);
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      logic [31:0] rdata;
      logic [1:0]  resp;
      if (v.is_write) begin
         axiWrite(v.addr, v.data, 0, 0, resp);
         checkOutput($sformatf("vec%0d_bresp", idx), 32'(resp), 32'(v.exp_resp));
         if (v.addr < NR * 4) model_regs[v.addr / 4] = v.data;
      end else begin
         axiRead(v.addr, rdata, resp);
         checkOutput($sformatf("vec%0d_rdata", idx), rdata, v.exp_rdata);
         checkOutput($sformatf("vec%0d_rresp", idx), 32'(resp), 32'(v.exp_resp));
      end
   endtask

   initial begin
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] old_val;
      int          b_before;
      int          cnt;

      vecs[0]  = '{1'b0, 32'h00, 32'h0,        32'h00000000, 2'b00};
      vecs[1]  = '{1'b0, 32'h04, 32'h0,        32'h00000000, 2'b00};
      vecs[2]  = '{1'b1, 32'h00, 32'hDEADBEEF, 32'h0,        2'b00};
      vecs[3]  = '{1'b0, 32'h00, 32'h0,        32'hDEADBEEF, 2'b00};
      vecs[4]  = '{1'b1, 32'h04, 32'hADADABAB, 32'h0,        2'b00};
      vecs[5]  = '{1'b0, 32'h04, 32'h0,        32'hADADABAB, 2'b00};
      vecs[6]  = '{1'b0, 32'h00, 32'h0,        32'hDEADBEEF, 2'b00};
      vecs[7]  = '{1'b1, 32'h10, 32'h12345678, 32'h0,        OOR_RESP};
      vecs[8]  = '{1'b0, 32'h10, 32'h0,        32'h00000000, OOR_RESP};
      vecs[9]  = '{1'b0, 32'h00, 32'h0,        32'hDEADBEEF, 2'b00};
      vecs[10] = '{1'b0, 32'h04, 32'h0,        32'hADADABAB, 2'b00};
      vecs[11] = '{1'b0, 32'h08, 32'h0,        32'h00000000, 2'b00};
      vecs[12] = '{1'b0, 32'h0C, 32'h0,        32'h00000000, 2'b00};
      vecs[13] = '{1'b1, 32'h0B, 32'h11112222, 32'h0,        2'b00};
      vecs[14] = '{1'b0, 32'h08, 32'h0,        32'h11112222, 2'b00};

      for (int i = 0; i < NR; i++) model_regs[i] = 32'h0;

      aresetn = 1'b0;
      s_axi_awaddr = '0;
      s_axi_awvalid = 1'b0;
      s_axi_wdata = '0;
      s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b1;
      s_axi_araddr = '0;
      s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b1;

      // Reset state.
      repeat (3) @(negedge aclk);
      checkOutput("rst_readies", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
      checkOutput("rst_valids", {30'h0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
      checkOutput("rst_rdata", s_axi_rdata, 32'h0);
      checkOutput("rst_resps", {28'h0, s_axi_bresp, s_axi_rresp}, 32'h0);

      // Readies come up on the second edge after release.
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      checkOutput("ready_edge1", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
      @(posedge aclk);
      #1;
      checkOutput("ready_edge2", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
      @(negedge aclk);

      // Directed vector table.
      for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

      // W three cycles ahead of AW, then AW and W in the same cycle.
      axiWrite(32'h0C, 32'hCAFEF00D, 3, 0, resp);
      checkOutput("w_first_bresp", 32'(resp), 32'h0);
      model_regs[3] = 32'hCAFEF00D;
      axiRead(32'h0C, rdata, resp);
      checkOutput("w_first_rdata", rdata, 32'hCAFEF00D);
      axiWrite(32'h0C, 32'h0BADCAFE, 0, 0, resp);
      model_regs[3] = 32'h0BADCAFE;
      axiRead(32'h0C, rdata, resp);
      checkOutput("same_cycle_rdata", rdata, 32'h0BADCAFE);

      // Backpressured write response must hold and block further writes.
      s_axi_bready = 1'b0;
      checkOutput("bp_ready_before", {30'h0, s_axi_awready, s_axi_wready}, 32'h3);
      s_axi_awaddr = 32'h08;
      s_axi_wdata = 32'h5A5A5A5A;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid = 1'b1;
      @(negedge aclk);
      b_before = b_hs_count;
      s_axi_awaddr = 32'h0C;
      s_axi_wdata = 32'hFFFF0000;
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_bvalid", 32'(s_axi_bvalid), 32'h1);
         checkOutput("bp_bresp", 32'(s_axi_bresp), 32'h0);
         checkOutput("bp_readies", {30'h0, s_axi_awready, s_axi_wready}, 32'h0);
         @(negedge aclk);
      end
      s_axi_awvalid = 1'b0;
      s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b1;
      @(negedge aclk);
      checkOutput("bp_bvalid_drop", 32'(s_axi_bvalid), 32'h0);
      checkOutput("bp_b_count", b_hs_count - b_before, 1);
      model_regs[2] = 32'h5A5A5A5A;
      axiRead(32'h0C, rdata, resp);
      checkOutput("bp_no_second_write", rdata, model_regs[3]);
      axiRead(32'h08, rdata, resp);
      checkOutput("bp_first_write", rdata, 32'h5A5A5A5A);

      // Read and write completing together on one register returns old data.
      old_val = model_regs[0];
      checkOutput("rw_readies", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
      s_axi_awaddr = 32'h00;
      s_axi_wdata = 32'h13572468;
      s_axi_araddr = 32'h00;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid = 1'b1;
      s_axi_arvalid = 1'b1;
      @(negedge aclk);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid = 1'b0;
      s_axi_arvalid = 1'b0;
      checkOutput("rw_valids", {30'h0, s_axi_bvalid, s_axi_rvalid}, 32'h3);
      checkOutput("rw_old_data", s_axi_rdata, old_val);
      @(negedge aclk);
      model_regs[0] = 32'h13572468;
      axiRead(32'h00, rdata, resp);
      checkOutput("rw_new_data", rdata, 32'h13572468);

      // Randomized traffic against the array model.
      for (int i = 0; i < 150; i++) begin
         addr = 32'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            data = $urandom;
            axiWrite(addr, data, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), resp);
            checkOutput("rand_bresp", 32'(resp), 32'(modelResp(addr)));
            if (addr < NR * 4) model_regs[addr / 4] = data;
         end else begin
            axiRead(addr, rdata, resp);
            checkOutput("rand_rdata", rdata, modelRead(addr));
            checkOutput("rand_rresp", 32'(resp), 32'(modelResp(addr)));
         end
      end

      // Reset in the middle of a held read response.
      axiWrite(32'h04, 32'hDADABBBB, 0, 0, resp);
      model_regs[1] = 32'hDADABBBB;
      s_axi_rready = 1'b0;
      s_axi_araddr = 32'h04;
      s_axi_arvalid = 1'b1;
      @(negedge aclk);
      s_axi_arvalid = 1'b0;
      cnt = 0;
      while (!s_axi_rvalid && cnt < 100) begin
         @(negedge aclk);
         cnt++;
      end
      if (!s_axi_rvalid) reportTimeout("rst_mid_read");
      checkOutput("rst_mid_rdata", s_axi_rdata, 32'hDADABBBB);
      @(negedge aclk);
      checkOutput("rst_mid_hold", {31'h0, s_axi_rvalid}, 32'h1);
      aresetn = 1'b0;
      #1;
      checkOutput("rst_mid_rvalid", {30'h0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
      checkOutput("rst_mid_rdata_clr", s_axi_rdata, 32'h0);
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      s_axi_rready = 1'b1;
      for (int i = 0; i < NR; i++) model_regs[i] = 32'h0;
      repeat (3) @(negedge aclk);
      checkOutput("post_rst_rvalid", {31'h0, s_axi_rvalid}, 32'h0);
      axiRead(32'h04, rdata, resp);
      checkOutput("post_rst_rdata", rdata, 32'h0);
      axiRead(32'h00, rdata, resp);
      checkOutput("post_rst_rdata0", rdata, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
